lc3_mem_io: RTL and testbench



---
 rtl/lc3_mem_pkg.sv | 33 +++
 rtl/lc3_kbd_fifo.sv | 48 ++++
 rtl/lc3_mem_io.sv | 96 +++++++++
 tb/tb_lc3_mem_io.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared address map and decode helper for the LC-3 memory / memory-mapped I/O block.
package lc3_mem_pkg;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam logic [15:0] MCR_ADDR  = 16'hFFFE;
    localparam logic [15:0] IO_BASE   = 16'hFE00;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_KBSR,
        SEL_KBDR,
        SEL_DSR,
        SEL_DDR,
        SEL_MCR,
        SEL_NONE
    } io_sel_e;

    function automatic io_sel_e decode(input logic [15:0] addr);
        if (addr < IO_BASE) return SEL_RAM;
        case (addr)
            KBSR_ADDR: return SEL_KBSR;
            KBDR_ADDR: return SEL_KBDR;
            DSR_ADDR:  return SEL_DSR;
            DDR_ADDR:  return SEL_DDR;
            MCR_ADDR:  return SEL_MCR;
            default:   return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/lc3_kbd_fifo.sv
// Keyboard receive FIFO; dout reads 0 while empty so KBDR needs no extra muxing.
module lc3_kbd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);
    localparam int PW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [PW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = empty ? 8'h00 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    // Power-of-2 depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/lc3_mem_io.sv
module lc3_mem_io
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter     INIT_FILE = "",
    parameter int KBD_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mar,
    input  logic [15:0] mdr,
    input  logic        memwe,
    output logic [15:0] memOut,
    input  logic [7:0]  kbd_data,
    input  logic        kbd_valid,
    output logic        kbd_ready,
    output logic [7:0]  disp_data,
    output logic        disp_valid,
    input  logic        disp_ready,
    output logic        halt
);
    logic [15:0] ram_q [2**ADDR_W];
    io_sel_e     sel;
    logic        kbdr_hit, kbdr_hit_q, kbd_pop;
    logic        fifo_empty, fifo_full;
    logic [7:0]  fifo_head;
    logic        disp_valid_q, disp_valid_d;
    logic [7:0]  disp_data_q, disp_data_d;
    logic [15:0] mcr_q, mcr_d;

    assign sel = decode(mar);

    always_ff @(posedge clk) begin
        if (memwe && sel == SEL_RAM) ram_q[mar[ADDR_W-1:0]] <= mdr;
    end

    assign kbdr_hit = (mar == KBDR_ADDR);
    assign kbd_pop  = kbdr_hit & ~kbdr_hit_q;

    lc3_kbd_fifo #(.DEPTH(KBD_DEPTH)) u_kbd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (kbd_valid),
        .din   (kbd_data),
        .pop   (kbd_pop),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign kbd_ready = ~fifo_full;

    always_comb begin
        disp_valid_d = disp_valid_q;
        disp_data_d  = disp_data_q;
        mcr_d        = mcr_q;
        if (disp_valid_q) begin
            if (disp_ready) disp_valid_d = 1'b0;
        end else if (memwe && sel == SEL_DDR) begin
            disp_valid_d = 1'b1;
            disp_data_d  = mdr[7:0];
        end
        if (memwe && sel == SEL_MCR) mcr_d = mdr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kbdr_hit_q   <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= 8'h00;
            mcr_q        <= 16'h8000;
        end else begin
            kbdr_hit_q   <= kbdr_hit;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
            mcr_q        <= mcr_d;
        end
    end

    always_comb begin
        memOut = 16'h0000;
        case (sel)
            SEL_RAM:  memOut = ram_q[mar[ADDR_W-1:0]];
            SEL_KBSR: memOut = {~fifo_empty, 15'b0};
            SEL_KBDR: memOut = {8'h00, fifo_head};
            SEL_DSR:  memOut = {~disp_valid_q, 15'b0};
            SEL_MCR:  memOut = mcr_q;
            default:  memOut = 16'h0000;
        endcase
    end

    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;
    assign halt       = ~mcr_q[15];

endmodule

// File: tb/tb_lc3_mem_io.sv
// Directed plus randomized bench for lc3_mem_io against a queue/array reference model.
module tb_lc3_mem_io;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mar, mdr;
    logic        memwe;
    logic [15:0] memOut;
    logic [7:0]  kbd_data;
    logic        kbd_valid, kbd_ready;
    logic [7:0]  disp_data;
    logic        disp_valid, disp_ready, halt;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [15:0] m_ram [256];
    logic [7:0]  q[$];
    bit          m_dv;
    logic [7:0]  m_dd;
    logic [15:0] m_mcr;
    bit          m_hitq;

    lc3_mem_io dut (
        .clk        (clk),
        .reset      (reset),
        .mar        (mar),
        .mdr        (mdr),
        .memwe      (memwe),
        .memOut     (memOut),
        .kbd_data   (kbd_data),
        .kbd_valid  (kbd_valid),
        .kbd_ready  (kbd_ready),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .halt       (halt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance the model by one edge using the inputs currently applied, then clock the DUT.
    task automatic tick();
        bit hit, pop, push;
        hit = (mar == 16'hFE02);
        if (memwe && mar < 16'hFE00) m_ram[mar[7:0]] = mdr;
        if (reset) begin
            q.delete();
            m_dv = 0; m_dd = 8'h00; m_mcr = 16'h8000; m_hitq = 0;
        end else begin
            pop  = hit && !m_hitq && q.size() > 0;
            push = kbd_valid && q.size() < 4;
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(kbd_data);
            if (m_dv) begin
                if (disp_ready) m_dv = 0;
            end else if (memwe && mar == 16'hFE06) begin
                m_dv = 1; m_dd = mdr[7:0];
            end
            if (memwe && mar == 16'hFFFE) m_mcr = mdr;
            m_hitq = hit;
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] exp_out();
        if (mar < 16'hFE00) return m_ram[mar[7:0]];
        case (mar)
            16'hFE00: return {(q.size() != 0), 15'b0};
            16'hFE02: return (q.size() != 0) ? {8'h00, q[0]} : 16'h0000;
            16'hFE04: return {~m_dv, 15'b0};
            16'hFFFE: return m_mcr;
            default:  return 16'h0000;
        endcase
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_memOut"}, memOut, exp_out());
        chk({tag, "_kbd_ready"}, {15'b0, kbd_ready}, {15'b0, (q.size() < 4)});
        chk({tag, "_disp_valid"}, {15'b0, disp_valid}, {15'b0, m_dv});
        chk({tag, "_disp_data"}, {8'h00, disp_data}, {8'h00, m_dd});
        chk({tag, "_halt"}, {15'b0, halt}, {15'b0, ~m_mcr[15]});
    endtask

    initial begin
        logic [15:0] pick [8];
        logic [7:0]  drain [3];
        reset = 1; mar = 16'h0000; mdr = 16'h0000; memwe = 0;
        kbd_data = 8'h00; kbd_valid = 0; disp_ready = 0;
        m_dv = 0; m_dd = 0; m_mcr = 16'h8000; m_hitq = 0;
        tick(); tick();
        reset = 0;

        // reset state
        chk("rst_kbd_ready", {15'b0, kbd_ready}, 16'h0001);
        chk("rst_disp_valid", {15'b0, disp_valid}, 16'h0000);
        chk("rst_disp_data", {8'h00, disp_data}, 16'h0000);
        chk("rst_halt", {15'b0, halt}, 16'h0000);
        mar = 16'hFFFE; #1 chk("rst_mcr", memOut, 16'h8000);
        mar = 16'hFE00; #1 chk("rst_kbsr", memOut, 16'h0000);
        mar = 16'hFE04; #1 chk("rst_dsr", memOut, 16'h8000);

        // give every RAM word a known value
        for (int i = 0; i < 256; i++) begin
            mar = 16'(i); mdr = 16'($urandom); memwe = 1; tick();
        end
        memwe = 0;

        // RAM write, read-after-write and aliasing
        mar = 16'h0010; mdr = 16'hBEEF; memwe = 1; tick();
        memwe = 0;
        chk("ram_rd", memOut, 16'hBEEF);
        mar = 16'h0110; #1 chk("ram_alias", memOut, 16'hBEEF);
        mar = 16'hFE10; mdr = 16'h1234; memwe = 1; tick();
        memwe = 0; #1 chk("io_hole_rd", memOut, 16'h0000);
        mar = 16'h0010; #1 chk("io_hole_nowrite", memOut, 16'hBEEF);

        // keyboard single pop per KBDR visit
        kbd_valid = 1; kbd_data = 8'h41; tick();
        kbd_data = 8'h42; tick();
        kbd_valid = 0;
        mar = 16'hFE00; #1 chk("kbsr_full", memOut, 16'h8000);
        mar = 16'hFE02; #1 chk("kbdr_c1", memOut, 16'h0041);
        tick(); chk("kbdr_c2", memOut, 16'h0042);
        tick(); chk("kbdr_c3_onepop", memOut, 16'h0042);
        mar = 16'h0000; tick();
        mar = 16'hFE02; #1 chk("kbdr_again", memOut, 16'h0042);
        tick(); chk("kbdr_empty", memOut, 16'h0000);
        mar = 16'hFE00; #1 chk("kbsr_empty", memOut, 16'h0000);

        // FIFO full / back-pressure
        mar = 16'h0000; kbd_valid = 1;
        for (int i = 0; i < 4; i++) begin
            kbd_data = 8'h50 + 8'(i); tick();
        end
        chk("fifo_full_ready", {15'b0, kbd_ready}, 16'h0000);
        kbd_data = 8'h54; tick();
        kbd_valid = 0;
        mar = 16'hFE02; #1 chk("fifo_head", memOut, 16'h0050);
        tick(); chk("fifo_slot_freed", {15'b0, kbd_ready}, 16'h0001);
        drain[0] = 8'h51; drain[1] = 8'h52; drain[2] = 8'h53;
        for (int i = 0; i < 3; i++) begin
            mar = 16'h0000; tick();
            mar = 16'hFE02; #1 chk("fifo_drain", memOut, {8'h00, drain[i]});
            tick();
        end
        chk("fifo_5th_dropped", memOut, 16'h0000);

        // display handshake
        mar = 16'hFE06; mdr = 16'h0058; memwe = 1; disp_ready = 0; tick();
        memwe = 0;
        chk("ddr_valid", {15'b0, disp_valid}, 16'h0001);
        chk("ddr_data", {8'h00, disp_data}, 16'h0058);
        chk("ddr_rd0", memOut, 16'h0000);
        mar = 16'hFE04; #1 chk("dsr_busy", memOut, 16'h0000);
        mar = 16'hFE06; mdr = 16'h0059; memwe = 1; tick();
        memwe = 0; chk("ddr_dropped", {8'h00, disp_data}, 16'h0058);
        disp_ready = 1; tick();
        disp_ready = 0;
        chk("disp_done", {15'b0, disp_valid}, 16'h0000);
        mar = 16'hFE04; #1 chk("dsr_idle", memOut, 16'h8000);
        chk("disp_hold", {8'h00, disp_data}, 16'h0058);
        mar = 16'hFE06; mdr = 16'h005A; memwe = 1; tick();
        mdr = 16'h005B; disp_ready = 1; tick();
        memwe = 0; disp_ready = 0;
        chk("ddr_hs_drop_valid", {15'b0, disp_valid}, 16'h0000);
        chk("ddr_hs_drop_data", {8'h00, disp_data}, 16'h005A);

        // MCR and reset
        mar = 16'hFFFE; mdr = 16'h7FFF; memwe = 1;
        #1 chk("halt_before", {15'b0, halt}, 16'h0000);
        tick();
        memwe = 0;
        chk("halt_set", {15'b0, halt}, 16'h0001);
        chk("mcr_rd", memOut, 16'h7FFF);
        mar = 16'h0000; kbd_valid = 1; kbd_data = 8'h77; tick();
        kbd_valid = 0;
        mar = 16'hFE06; mdr = 16'h0061; memwe = 1; tick();
        memwe = 0; reset = 1; tick();
        reset = 0;
        chk("rst2_halt", {15'b0, halt}, 16'h0000);
        chk("rst2_disp_valid", {15'b0, disp_valid}, 16'h0000);
        mar = 16'hFFFE; #1 chk("rst2_mcr", memOut, 16'h8000);
        mar = 16'hFE00; #1 chk("rst2_kbsr", memOut, 16'h0000);
        mar = 16'h0010; #1 chk("rst2_ram_kept", memOut, 16'hBEEF);

        // randomized traffic against the model
        pick[0] = 16'hFE00; pick[1] = 16'hFE02; pick[2] = 16'hFE04; pick[3] = 16'hFE06;
        pick[4] = 16'hFFFE; pick[5] = 16'hFE08; pick[6] = 16'h0000; pick[7] = 16'h0000;
        for (int c = 0; c < 1500; c++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: mar = pick[$urandom_range(0, 5)];
                6, 7:             mar = 16'($urandom_range(0, 16'hFDFF));
                default:          mar = 16'($urandom);
            endcase
            if (mar == 16'hFFFE) mdr = 16'($urandom) | 16'h8000;
            else                 mdr = 16'($urandom);
            if ($urandom_range(0, 63) == 0) mdr[15] = 1'b0;
            memwe      = ($urandom_range(0, 9) < 3);
            kbd_valid  = ($urandom_range(0, 1) == 1);
            kbd_data   = 8'($urandom);
            disp_ready = ($urandom_range(0, 9) < 4);
            reset      = ($urandom_range(0, 59) == 0);
            #1 check_all("rnd_pre");
            tick();
            check_all("rnd_post");
        end
        reset = 0; memwe = 0; kbd_valid = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
